// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin or fixed-priority grant, sub-word load
// extraction, and read-modify-write sequencing for byte/halfword stores.
module dmem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [1:0]  p0_req_size,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [1:0]  p1_req_size,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        gnt_r, last_grant_r, win_s, accept_s, err_s;
  logic        we_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, old_r;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] lane);
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   extract = {24'h000000, w[7:0]};
          2'b01:   extract = {24'h000000, w[15:8]};
          2'b10:   extract = {24'h000000, w[23:16]};
          default: extract = {24'h000000, w[31:24]};
        endcase
      end
      2'b01:   extract = lane[1] ? {16'h0000, w[31:16]} : {16'h0000, w[15:0]};
      2'b10:   extract = w;
      default: extract = 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   merge = {old[31:8], wd[7:0]};
          2'b01:   merge = {old[31:16], wd[7:0], old[7:0]};
          2'b10:   merge = {old[31:24], wd[7:0], old[15:0]};
          default: merge = {wd[7:0], old[23:0]};
        endcase
      end
      2'b01:   merge = lane[1] ? {wd[15:0], old[15:0]} : {old[31:16], wd[15:0]};
      default: merge = old;
    endcase
  endfunction

  // Arbitration, next-state and memory-side decode
  always_comb begin
    state_s        = state_r;
    accept_s       = 1'b0;
    p0_req_ready   = 1'b0;
    p1_req_ready   = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = {addr_r[31:2], 2'b00};
    mem_write_data = wdata_r;
    err_s          = misaligned(size_r, addr_r[1:0]);
    if (p0_req_valid && p1_req_valid) begin
      win_s = RR_EN ? ~last_grant_r : 1'b0;
    end else begin
      win_s = p1_req_valid;
    end
    case (state_r)
      IDLE: begin
        if (!rst && (p0_req_valid || p1_req_valid)) begin
          accept_s     = 1'b1;
          p0_req_ready = ~win_s;
          p1_req_ready = win_s;
          state_s      = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (err_s) begin
          state_s = RESP;
        end else begin
          mem_read_en = ~rst;
          if (we_r && (size_r == 2'b10)) begin
            mem_write_en = ~rst;
            state_s      = RESP;
          end else if (we_r) begin
            state_s = MERGE;
          end else begin
            state_s = RESP;
          end
        end
      end
      MERGE: begin
        // Gating with rst drops the pending write if reset lands mid-RMW
        mem_write_en   = ~rst;
        mem_write_data = merge(old_r, wdata_r, size_r, addr_r[1:0]);
        state_s        = RESP;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request latch, load capture and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      gnt_r        <= 1'b0;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      size_r       <= 2'b00;
      addr_r       <= 32'h00000000;
      wdata_r      <= 32'h00000000;
      old_r        <= 32'h00000000;
      rsp_rdata    <= 32'h00000000;
      rsp_err      <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        gnt_r        <= win_s;
        last_grant_r <= win_s;
        we_r         <= win_s ? p1_req_we    : p0_req_we;
        size_r       <= win_s ? p1_req_size  : p0_req_size;
        addr_r       <= win_s ? p1_req_addr  : p0_req_addr;
        wdata_r      <= win_s ? p1_req_wdata : p0_req_wdata;
      end
      if (state_r == ACCESS) begin
        old_r     <= mem_read_data;
        rsp_err   <= err_s;
        rsp_rdata <= (err_s || we_r) ? 32'h00000000 : extract(mem_read_data, size_r, addr_r[1:0]);
      end
      p0_rsp_valid <= (state_s == RESP) && !gnt_r;
      p1_rsp_valid <= (state_s == RESP) && gnt_r;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: word-memory model, one task per scenario,
// plus a fixed-priority instance for the RR_EN = 0 check.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
  logic [1:0]  p0_req_size = 2'b00;
  logic [31:0] p0_req_addr = 32'h0, p0_req_wdata = 32'h0;
  logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
  logic [1:0]  p1_req_size = 2'b00;
  logic [31:0] p1_req_addr = 32'h0, p1_req_wdata = 32'h0;
  logic        p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        mem_read_en, mem_write_en;

  logic        f_p0_req_valid = 1'b0, f_p1_req_valid = 1'b0;
  logic        f_p0_req_ready, f_p1_req_ready, f_p0_rsp_valid, f_p1_rsp_valid, f_rsp_err;
  logic [31:0] f_rsp_rdata, f_mem_addr, f_mem_write_data, f_mem_read_data;
  logic        f_mem_read_en, f_mem_write_en;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'h0;
  logic        mon = 1'b0, saw_en = 1'b0;
  int          pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  assign mem_read_data   = mem[mem_addr[7:2]];
  assign f_mem_read_data = f_mem_addr ^ 32'hA5A50000;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[7:2]] <= mem_write_data;
    else if (pl_en)   mem[pl_idx] <= pl_data;
  end

  always @(negedge clk) if (mon && (mem_read_en || mem_write_en)) saw_en = 1'b1;

  dmem_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req_valid(f_p0_req_valid), .p0_req_ready(f_p0_req_ready), .p0_req_we(1'b0),
    .p0_req_size(2'b10), .p0_req_addr(32'h00000040), .p0_req_wdata(32'h0),
    .p0_rsp_valid(f_p0_rsp_valid),
    .p1_req_valid(f_p1_req_valid), .p1_req_ready(f_p1_req_ready), .p1_req_we(1'b0),
    .p1_req_size(2'b10), .p1_req_addr(32'h00000044), .p1_req_wdata(32'h0),
    .p1_rsp_valid(f_p1_rsp_valid),
    .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err),
    .mem_read_en(f_mem_read_en), .mem_write_en(f_mem_write_en), .mem_addr(f_mem_addr),
    .mem_write_data(f_mem_write_data), .mem_read_data(f_mem_read_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_p0(input logic v, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    p0_req_valid = v; p0_req_we = we; p0_req_size = sz; p0_req_addr = a; p0_req_wdata = wd;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    p1_req_valid = v; p1_req_we = we; p1_req_size = sz; p1_req_addr = a; p1_req_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p0_req_valid = 1'b1;
    tick(); tick();
    smp();
    total_cnt++; if (p0_req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", p0_req_ready); else pass_cnt++;
    tick();
    p0_req_valid = 1'b0;
    rst = 1'b0;
    smp();
    total_cnt++; if ({p1_rsp_valid, p0_rsp_valid} !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", {p1_rsp_valid, p0_rsp_valid}); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata); else pass_cnt++;
    total_cnt++; if ({mem_read_en, mem_write_en} !== 2'b00) $display("FAIL rst_mem_en: got %b want 00", {mem_read_en, mem_write_en}); else pass_cnt++;
    tick();
  endtask

  task automatic test_load_word();
    preload(6'd4, 32'hAABBCCDD);
    set_p0(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    smp();
    total_cnt++; if ({p1_req_ready, p0_req_ready} !== 2'b01) $display("FAIL lw_ready: got %b want 01", {p1_req_ready, p0_req_ready}); else pass_cnt++;
    tick(); p0_req_valid = 1'b0;
    smp();
    total_cnt++; if ({mem_read_en, mem_write_en} !== 2'b10) $display("FAIL lw_mem_en: got %b want 10", {mem_read_en, mem_write_en}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h10) $display("FAIL lw_mem_addr: got %h want 00000010", mem_addr); else pass_cnt++;
    total_cnt++; if (p0_rsp_valid !== 1'b0) $display("FAIL lw_early_rsp: got %b want 0", p0_rsp_valid); else pass_cnt++;
    tick();
    smp();
    total_cnt++; if ({p1_rsp_valid, p0_rsp_valid} !== 2'b01) $display("FAIL lw_rsp_valid: got %b want 01", {p1_rsp_valid, p0_rsp_valid}); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'hAABBCCDD) $display("FAIL lw_rdata: got %h want aabbccdd", rsp_rdata); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL lw_err: got %b want 0", rsp_err); else pass_cnt++;
    tick();
    smp();
    total_cnt++; if (p0_rsp_valid !== 1'b0) $display("FAIL lw_pulse: got %b want 0", p0_rsp_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_byte_store();
    set_p0(1'b1, 1'b1, 2'b00, 32'h11, 32'h00000055);
    smp();
    total_cnt++; if (p0_req_ready !== 1'b1) $display("FAIL sb_ready: got %b want 1", p0_req_ready); else pass_cnt++;
    tick(); p0_req_valid = 1'b0;
    smp();
    total_cnt++; if ({mem_read_en, mem_write_en} !== 2'b10) $display("FAIL sb_read_phase: got %b want 10", {mem_read_en, mem_write_en}); else pass_cnt++;
    tick();
    smp();
    total_cnt++; if ({mem_read_en, mem_write_en} !== 2'b01) $display("FAIL sb_merge_en: got %b want 01", {mem_read_en, mem_write_en}); else pass_cnt++;
    total_cnt++; if (mem_write_data !== 32'hAABB55DD) $display("FAIL sb_wdata: got %h want aabb55dd", mem_write_data); else pass_cnt++;
    total_cnt++; if (p0_rsp_valid !== 1'b0) $display("FAIL sb_early_rsp: got %b want 0", p0_rsp_valid); else pass_cnt++;
    tick();
    smp();
    total_cnt++; if (p0_rsp_valid !== 1'b1) $display("FAIL sb_rsp: got %b want 1", p0_rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL sb_rdata: got %h want 0", rsp_rdata); else pass_cnt++;
    total_cnt++; if (mem[4] !== 32'hAABB55DD) $display("FAIL sb_mem: got %h want aabb55dd", mem[4]); else pass_cnt++;
    tick();
    set_p0(1'b1, 1'b0, 2'b01, 32'h12, 32'h0);
    smp();
    tick(); p0_req_valid = 1'b0;
    tick();
    smp();
    total_cnt++; if (p0_rsp_valid !== 1'b1) $display("FAIL lh_rsp: got %b want 1", p0_rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'h0000AABB) $display("FAIL lh_rdata: got %h want 0000aabb", rsp_rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    preload(6'd8, 32'h11111111);
    preload(6'd9, 32'h22222222);
    set_p0(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    set_p1(1'b1, 1'b0, 2'b10, 32'h24, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1) ? 2'b10 : 2'b01;
      smp();
      total_cnt++; if ({p1_req_ready, p0_req_ready} !== exp) $display("FAIL rr_grant%0d: got %b want %b", i, {p1_req_ready, p0_req_ready}, exp); else pass_cnt++;
      tick(); tick();
      smp();
      total_cnt++; if ({p1_rsp_valid, p0_rsp_valid} !== exp) $display("FAIL rr_rsp%0d: got %b want %b", i, {p1_rsp_valid, p0_rsp_valid}, exp); else pass_cnt++;
      total_cnt++; if (rsp_rdata !== (exp[1] ? 32'h22222222 : 32'h11111111)) $display("FAIL rr_rdata%0d: got %h", i, rsp_rdata); else pass_cnt++;
      tick();
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_error();
    saw_en = 1'b0; mon = 1'b1;
    set_p0(1'b1, 1'b0, 2'b10, 32'h13, 32'h0);
    smp();
    tick(); p0_req_valid = 1'b0;
    tick();
    smp();
    total_cnt++; if (p0_rsp_valid !== 1'b1) $display("FAIL err_mis_rsp: got %b want 1", p0_rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b1) $display("FAIL err_mis_err: got %b want 1", rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL err_mis_rdata: got %h want 0", rsp_rdata); else pass_cnt++;
    tick();
    set_p1(1'b1, 1'b1, 2'b11, 32'h0, 32'hFFFFFFFF);
    smp();
    total_cnt++; if (p1_req_ready !== 1'b1) $display("FAIL err_sz_ready: got %b want 1", p1_req_ready); else pass_cnt++;
    tick(); p1_req_valid = 1'b0;
    tick();
    smp();
    total_cnt++; if ({p1_rsp_valid, p0_rsp_valid} !== 2'b10) $display("FAIL err_sz_rsp: got %b want 10", {p1_rsp_valid, p0_rsp_valid}); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b1) $display("FAIL err_sz_err: got %b want 1", rsp_err); else pass_cnt++;
    tick();
    mon = 1'b0;
    total_cnt++; if (saw_en !== 1'b0) $display("FAIL err_no_mem: got %b want 0", saw_en); else pass_cnt++;
  endtask

  task automatic test_reset_in_merge();
    preload(6'd5, 32'h12345678);
    set_p0(1'b1, 1'b1, 2'b01, 32'h16, 32'h0000BEEF);
    smp();
    tick(); p0_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    smp();
    total_cnt++; if (mem_write_en !== 1'b0) $display("FAIL rm_gate: got %b want 0", mem_write_en); else pass_cnt++;
    tick();
    rst = 1'b0;
    smp();
    total_cnt++; if ({p1_rsp_valid, p0_rsp_valid, rsp_err} !== 3'b000) $display("FAIL rm_outs: got %b want 000", {p1_rsp_valid, p0_rsp_valid, rsp_err}); else pass_cnt++;
    total_cnt++; if (mem[5] !== 32'h12345678) $display("FAIL rm_mem: got %h want 12345678", mem[5]); else pass_cnt++;
    tick();
    smp();
    total_cnt++; if (p0_rsp_valid !== 1'b0) $display("FAIL rm_dropped: got %b want 0", p0_rsp_valid); else pass_cnt++;
    tick();
    set_p0(1'b1, 1'b0, 2'b10, 32'h14, 32'h0);
    smp();
    total_cnt++; if (p0_req_ready !== 1'b1) $display("FAIL rm_next_ready: got %b want 1", p0_req_ready); else pass_cnt++;
    tick(); p0_req_valid = 1'b0;
    tick();
    smp();
    total_cnt++; if (rsp_rdata !== 32'h12345678) $display("FAIL rm_next_rdata: got %h want 12345678", rsp_rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_fixed_priority();
    f_p0_req_valid = 1'b1; f_p1_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      total_cnt++; if ({f_p1_req_ready, f_p0_req_ready} !== 2'b01) $display("FAIL fp_grant%0d: got %b want 01", i, {f_p1_req_ready, f_p0_req_ready}); else pass_cnt++;
      tick(); tick();
      smp();
      total_cnt++; if (f_p0_rsp_valid !== 1'b1 || f_rsp_rdata !== 32'hA5A50040) $display("FAIL fp_rsp%0d: got %b/%h want 1/a5a50040", i, f_p0_rsp_valid, f_rsp_rdata); else pass_cnt++;
      tick();
    end
    f_p0_req_valid = 1'b0;
    smp();
    total_cnt++; if ({f_p1_req_ready, f_p0_req_ready} !== 2'b10) $display("FAIL fp_p1_grant: got %b want 10", {f_p1_req_ready, f_p0_req_ready}); else pass_cnt++;
    tick(); f_p1_req_valid = 1'b0;
    tick();
    smp();
    total_cnt++; if (f_p1_rsp_valid !== 1'b1 || f_rsp_rdata !== 32'hA5A50044) $display("FAIL fp_p1_rsp: got %b/%h want 1/a5a50044", f_p1_rsp_valid, f_rsp_rdata); else pass_cnt++;
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_load_word();
    test_byte_store();
    test_round_robin();
    test_error();
    test_reset_in_merge();
    test_fixed_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates and sequences data-memory traffic from two requesters (port 0: CPU load/store unit, port 1: debug/DMA) onto one word-wide data memory with synchronous write and asynchronous read. Byte and halfword stores are converted into read-modify-write sequences, and sub-word loads are extracted and zero-extended. Each port receives a one-cycle response pulse. The block sits between the core/debug logic and the data memory.

## Interface
- RR_EN, default 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; synchronous, active-high.
- pN_req_valid  in  1  port N (N = 0, 1) request valid.
- pN_req_ready  out  1  port N request accepted this cycle.
- pN_req_we  in  1  1 = store, 0 = load.
- pN_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- pN_req_addr  in  32  byte address.
- pN_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- pN_rsp_valid  out  1  one-cycle response pulse to port N.
- rsp_rdata  out  32  load data, zero-extended; 0 for stores and errors. Shared by both ports.
- rsp_err  out  1  misaligned or illegal-size request; valid with pN_rsp_valid.
- mem_read_en  out  1  memory read enable.
- mem_write_en  out  1  memory write enable (word write at posedge).
- mem_addr  out  32  memory byte address; always issued word-aligned ([1:0] = 0).
- mem_write_data  out  32  word to write.
- mem_read_data  in  32  asynchronous read data for mem_addr.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP.
- **IDLE**
  - If any pN_req_valid: select a winner and assert its pN_req_ready (combinational, IDLE only). Latch we/size/addr/wdata and the grant id. Go to ACCESS.
  - The losing port sees ready = 0 and must hold its request.
- **Arbitration (RR_EN = 1)**
  - Single requester wins.
  - Both valid: the port not granted last wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- **Alignment check (in ACCESS)**
  - Error conditions: size 11; half with addr[0] = 1; word with addr[1:0] != 0.
  - On error: no memory enables, rsp_err = 1, rdata = 0. Go to RESP.
- **ACCESS**
  - mem_addr = {addr[31:2], 2'b00}; mem_read_en = 1.
  - Load: capture mem_read_data, extract the lane (byte lane addr[1:0], half lane addr[1]), zero-extend. Go to RESP.
  - Word store: mem_write_en = 1, mem_write_data = wdata. Go to RESP.
  - Byte/half store: capture mem_read_data as old word. Go to MERGE.
- **MERGE**
  - mem_write_en = 1.
  - mem_write_data = old word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other bytes unchanged.
  - Go to RESP.
- **RESP**
  - Pulse the granted pN_rsp_valid with registered rsp_rdata/rsp_err. Go to IDLE.
- Memory enables are 0 in IDLE and RESP; mem_read_en = 0 in MERGE.

## Timing
- Cycle numbering: handshake cycle = T.
- Load or word store: pN_rsp_valid at T+2.
- Byte/half store: pN_rsp_valid at T+3; memory written at the posedge ending T+2.
- Error: pN_rsp_valid at T+2; no memory access.
- Throughput: next accept is possible at RESP+1 (IDLE). No back-to-back accept inside a transaction.
- A store's write is visible to a load accepted after the store's RESP.
- Reset (any state, mid-RMW included):
  - Next cycle: state IDLE; all ready, rsp_valid, rsp_err, mem enables = 0; rsp_rdata = 0; last_grant = 1.
  - The in-flight transaction is dropped with no response.
  - An MERGE write is not issued if rst is high in that cycle.
- pN_req_valid deasserting while not ready is tolerated; nothing is latched.

## Test plan
- Reset, then: mem[0x10] = 0xAABBCCDD; p0 load word @0x10 -> p0_rsp_valid at T+2, rdata 0xAABBCCDD, err 0.
- Byte store @0x11 wdata 0x55 on mem word 0xAABBCCDD -> read at T+1, write 0xAABB55DD at T+2, rsp at T+3; a following half load @0x12 returns 0x0000AABB.
- p0 and p1 both hold valid continuously -> grants alternate p0, p1, p0, p1; each response goes only to its own port.
- Word load @0x13 and size 11 @0x0 -> rsp_err = 1, rdata 0, mem_read_en/mem_write_en never asserted.
- Assert rst during MERGE of a half store -> no write occurs, memory word is unchanged, outputs are 0 next cycle, the next request is served normally.
- RR_EN = 0 with both ports valid -> port 0 is granted every time until its valid drops.
